// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin front end that shares one multi-cycle FP adder
// among NUM_REQ requesters. One request is in flight at a time: it is accepted,
// issued to the adder with a one-cycle start pulse, and its result is captured
// FPU_LAT edges later and returned on the response channel.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         per-requester handshake (ready is one-hot or zero)
//   req_a/req_b/req_tag         packed per-requester operands and tag
//   fpu_a/fpu_b/fpu_valid       operands and start pulse to the shared adder
//   fpu_sum/fpu_error           adder result, valid FPU_LAT edges after start
//   rsp_valid/rsp_ready         response handshake
//   rsp_id/rsp_tag              owner of the response and its echoed tag
//   rsp_sum/rsp_error           captured adder result
//   busy                        high whenever a request is in progress
module fp_add_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned FPU_LAT = 5,
    parameter int unsigned TAG_W   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*32-1:0]        req_a,
    input  logic [NUM_REQ*32-1:0]        req_b,
    input  logic [NUM_REQ*TAG_W-1:0]     req_tag,
    output logic [31:0]                  fpu_a,
    output logic [31:0]                  fpu_b,
    output logic                         fpu_valid,
    input  logic [31:0]                  fpu_sum,
    input  logic                         fpu_error,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [TAG_W-1:0]             rsp_tag,
    output logic [31:0]                  rsp_sum,
    output logic                         rsp_error,
    output logic                         busy
);

    localparam int unsigned ID_W   = $clog2(NUM_REQ);
    localparam int unsigned CNT_W  = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     ptr_next;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [ID_W-1:0]     winner;
    logic                grant_any;
    logic [ID_W:0]       scan_idx;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [TAG_W-1:0]    sel_tag;
    logic                accept;
    logic                capture;

    logic [DATA_W-1:0]   hold_a;
    logic [DATA_W-1:0]   hold_b;
    logic [TAG_W-1:0]    hold_tag;
    logic [ID_W-1:0]     hold_id;
    logic [DATA_W-1:0]   sum_q;
    logic                err_q;

    // Round-robin scan: first valid requester at or above ptr, wrapping.
    always_comb begin
        winner    = '0;
        grant_any = 1'b0;
        scan_idx  = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            scan_idx = {1'b0, ptr} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_any && req_valid[scan_idx[ID_W-1:0]]) begin
                winner    = scan_idx[ID_W-1:0];
                grant_any = 1'b1;
            end
        end
    end

    // Winner's operand/tag mux.
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_tag = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (winner == ID_W'(i)) begin
                sel_a   = req_a[i*DATA_W +: DATA_W];
                sel_b   = req_b[i*DATA_W +: DATA_W];
                sel_tag = req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, grant and control decode.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        accept     = 1'b0;
        capture    = 1'b0;
        cnt_next   = cnt;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    req_ready[winner] = 1'b1;
                    accept            = 1'b1;
                    state_next        = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next   = CNT_W'(FPU_LAT - 1);
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                    ptr_next   = (hold_id == ID_W'(NUM_REQ - 1)) ? '0 : hold_id + ID_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: holding registers, latency counter, result capture, pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            cnt      <= '0;
            hold_a   <= '0;
            hold_b   <= '0;
            hold_tag <= '0;
            hold_id  <= '0;
            sum_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            ptr <= ptr_next;
            cnt <= cnt_next;
            if (accept) begin
                hold_a   <= sel_a;
                hold_b   <= sel_b;
                hold_tag <= sel_tag;
                hold_id  <= winner;
            end
            if (capture) begin
                sum_q <= fpu_sum;
                err_q <= fpu_error;
            end
        end
    end

    // Outputs come straight from registers or decoded registered state.
    assign fpu_a     = hold_a;
    assign fpu_b     = hold_b;
    assign fpu_valid = (state == ISSUE);
    assign rsp_valid = (state == RESP);
    assign rsp_id    = hold_id;
    assign rsp_tag   = hold_tag;
    assign rsp_sum   = sum_q;
    assign rsp_error = err_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench for fp_add_arbiter with a stand-in fixed-latency adder.
module tb_fp_add_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned FPU_LAT = 5;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*32-1:0]     req_a;
    logic [NUM_REQ*32-1:0]     req_b;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [31:0]               fpu_a;
    logic [31:0]               fpu_b;
    logic                      fpu_valid;
    logic [31:0]               fpu_sum;
    logic                      fpu_error;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [TAG_W-1:0]          rsp_tag;
    logic [31:0]               rsp_sum;
    logic                      rsp_error;
    logic                      busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp_add_arbiter #(.NUM_REQ(NUM_REQ), .FPU_LAT(FPU_LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_valid(fpu_valid),
        .fpu_sum(fpu_sum), .fpu_error(fpu_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_sum(rsp_sum),
        .rsp_error(rsp_error), .busy(busy)
    );

    // Stand-in adder: known answers for the plan's operands, a scrambled
    // integer sum otherwise; garbage outside the single valid result cycle.
    function automatic logic fake_err(input logic [31:0] a, input logic [31:0] b);
        return (a[30:0] == 31'h7F800000) && (b[30:0] == 31'h7F800000) && (a[31] != b[31]);
    endfunction

    function automatic logic [31:0] fake_sum(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (fake_err(a, b)) return 32'h7FFFFFFF;
        return a + {b[15:0], b[31:16]};
    endfunction

    logic        pv [FPU_LAT];
    logic [31:0] pa [FPU_LAT];
    logic [31:0] pb [FPU_LAT];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(FPU_LAT); i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= fpu_valid;
            pa[0] <= fpu_a;
            pb[0] <= fpu_b;
            for (int i = 1; i < int'(FPU_LAT); i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
                pb[i] <= pb[i-1];
            end
        end
    end

    assign fpu_sum   = pv[FPU_LAT-1] ? fake_sum(pa[FPU_LAT-1], pb[FPU_LAT-1]) : 32'hDEADBEEF;
    assign fpu_error = pv[FPU_LAT-1] ? fake_err(pa[FPU_LAT-1], pb[FPU_LAT-1]) : 1'b1;

    // Round-robin rule: first valid index at or after ptr, modulo NUM_REQ.
    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 0; k < int'(NUM_REQ); k++)
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        return -1;
    endfunction

    function automatic int grant_idx(input logic [NUM_REQ-1:0] r);
        for (int i = 0; i < int'(NUM_REQ); i++) if (r[i]) return i;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] t);
        req_a[i*32 +: 32]      = a;
        req_b[i*32 +: 32]      = b;
        req_tag[i*TAG_W +: TAG_W] = t;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0; req_tag = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({req_ready, fpu_a, fpu_b, fpu_valid, rsp_valid, rsp_id, rsp_tag, rsp_sum, rsp_error, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b fa=%h fb=%h fv=%b rv=%b id=%0d tag=%h sum=%h err=%b busy=%b, required all 0",
                     req_ready, fpu_a, fpu_b, fpu_valid, rsp_valid, rsp_id, rsp_tag, rsp_sum, rsp_error, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || req_ready !== '0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b ready=%b rv=%b, required 0", busy, req_ready, rsp_valid);
        end
    endtask

    task automatic test_single;
        @(negedge clk);
        rsp_ready = 1'b1;
        set_req(0, 32'h3F800000, 32'h40000000, 4'd5);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL single_ready: got %b required 0001", req_ready);
        end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            checks++;
            if (fpu_valid !== (c == 1)) begin
                errors++; $display("FAIL single_fpu_valid c%0d: got %b required %b", c, fpu_valid, (c == 1));
            end
            checks++;
            if (busy !== (c <= 7)) begin
                errors++; $display("FAIL single_busy c%0d: got %b required %b", c, busy, (c <= 7));
            end
            checks++;
            if (rsp_valid !== (c == 7)) begin
                errors++; $display("FAIL single_rsp_valid c%0d: got %b required %b", c, rsp_valid, (c == 7));
            end
            if (c <= 6) begin
                checks++;
                if (fpu_a !== 32'h3F800000 || fpu_b !== 32'h40000000) begin
                    errors++; $display("FAIL single_operands c%0d: got %h %h required 3f800000 40000000", c, fpu_a, fpu_b);
                end
            end
            if (c == 7) begin
                checks++;
                if (rsp_sum !== 32'h40400000 || rsp_id !== 2'd0 || rsp_tag !== 4'd5 || rsp_error !== 1'b0) begin
                    errors++;
                    $display("FAIL single_rsp: got sum=%h id=%0d tag=%0d err=%b required 40400000 0 5 0",
                             rsp_sum, rsp_id, rsp_tag, rsp_error);
                end
            end
        end
    endtask

    // Pointer is 1 after the single request completed.
    task automatic test_exception;
        bit seen;
        @(negedge clk);
        rsp_ready = 1'b1;
        set_req(1, 32'h7F800000, 32'hFF800000, 4'hC);
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL exc_ready: got %b required 0010", req_ready);
        end
        seen = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            if (rsp_valid) begin
                seen = 1'b1;
                checks++;
                if (c != int'(FPU_LAT) + 2) begin
                    errors++; $display("FAIL exc_latency: got cycle %0d required %0d", c, FPU_LAT + 2);
                end
                checks++;
                if (rsp_sum !== 32'h7FFFFFFF || rsp_error !== 1'b1 || rsp_id !== 2'd1 || rsp_tag !== 4'hC) begin
                    errors++;
                    $display("FAIL exc_rsp: got sum=%h err=%b id=%0d tag=%h required 7fffffff 1 1 c",
                             rsp_sum, rsp_error, rsp_id, rsp_tag);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL exc_timeout: rsp_valid=0 required 1 within 20 cycles");
        end
    endtask

    task automatic test_contention;
        int grants[$];
        int exp_g[4] = '{0, 1, 3, 0};
        do_reset();
        for (int i = 0; i < int'(NUM_REQ); i++) set_req(i, 32'h1000 + i, 32'h2000 + i, TAG_W'(i));
        for (int c = 0; c < 80 && grants.size() < 4; c++) begin
            @(negedge clk);
            req_valid = 4'b1011;
            #1;
            checks++;
            if (!$onehot0(req_ready)) begin
                errors++; $display("FAIL cont_onehot: got %b required one-hot or zero", req_ready);
            end
            if (req_ready != '0) grants.push_back(grant_idx(req_ready));
        end
        req_valid = '0;
        checks++;
        if (grants.size() != 4) begin
            errors++; $display("FAIL cont_count: got %0d grants required 4", grants.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (grants[i] != exp_g[i]) begin
                    errors++; $display("FAIL cont_order[%0d]: got %0d required %0d", i, grants[i], exp_g[i]);
                end
            end
        end
    endtask

    task automatic test_fairness;
        int grants[$];
        int exp_g[3] = '{2, 1, 2};
        logic [NUM_REQ-1:0] v;
        do_reset();
        v = 4'b0100;
        for (int c = 0; c < 80 && grants.size() < 3; c++) begin
            @(negedge clk);
            if (grants.size() >= 1 && grants[grants.size()-1] == 2 && grants.size() == 1) v[1] = 1'b1;
            req_valid = v;
            #1;
            if (req_ready != '0) begin
                grants.push_back(grant_idx(req_ready));
                if (req_ready[1]) v[1] = 1'b0;
            end
        end
        req_valid = '0;
        checks++;
        if (grants.size() != 3) begin
            errors++; $display("FAIL fair_count: got %0d grants required 3", grants.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (grants[i] != exp_g[i]) begin
                    errors++; $display("FAIL fair_order[%0d]: got %0d required %0d", i, grants[i], exp_g[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        bit seen;
        logic [31:0] exp_sum;
        do_reset();
        exp_sum = fake_sum(32'h12345678, 32'h0F0F0F0F);
        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(0, 32'h12345678, 32'h0F0F0F0F, 4'hA);
        req_valid = 4'b0001;
        seen = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            req_valid = 4'b1110;
            #1;
            seen = rsp_valid;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL bp_timeout: rsp_valid=0 required 1 within 20 cycles");
        end
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            checks++;
            if (rsp_valid !== 1'b1 || rsp_sum !== exp_sum || rsp_id !== 2'd0 || rsp_tag !== 4'hA || rsp_error !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold c%0d: got rv=%b sum=%h id=%0d tag=%h err=%b required 1 %h 0 a 0",
                         c, rsp_valid, rsp_sum, rsp_id, rsp_tag, rsp_error, exp_sum);
            end
            checks++;
            if (req_ready !== '0 || fpu_valid !== 1'b0) begin
                errors++; $display("FAIL bp_stall c%0d: got ready=%b fv=%b required 0 0", c, req_ready, fpu_valid);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++; $display("FAIL bp_release: rsp_valid=%b required 1", rsp_valid);
        end
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_idle: got rv=%b busy=%b ready=%b required 0 0 0010", rsp_valid, busy, req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid_wait;
        bit seen;
        do_reset();
        // Complete one request from requester 1 so the pointer moves to 2.
        @(negedge clk);
        set_req(1, 32'h1, 32'h2, 4'h3);
        req_valid = 4'b0010;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk); req_valid = '0; #1; seen = rsp_valid;
        end
        @(negedge clk);
        set_req(2, 32'hAAAA0000, 32'h5555, 4'h7);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL rmw_ptr2: got %b required 0100", req_ready);
        end
        @(negedge clk); req_valid = '0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        checks++;
        if ({req_ready, fpu_a, fpu_b, fpu_valid, rsp_valid, rsp_id, rsp_tag, rsp_sum, rsp_error, busy} !== '0) begin
            errors++;
            $display("FAIL rmw_outputs: ready=%b fa=%h fb=%h fv=%b rv=%b id=%0d tag=%h sum=%h err=%b busy=%b, required all 0",
                     req_ready, fpu_a, fpu_b, fpu_valid, rsp_valid, rsp_id, rsp_tag, rsp_sum, rsp_error, busy);
        end
        for (int c = 0; c < 15; c++) begin
            @(negedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL rmw_dropped c%0d: rv=%b busy=%b required 0 0", c, rsp_valid, busy);
            end
        end
        @(negedge clk);
        set_req(0, 32'h00010001, 32'h00020002, 4'h9);
        req_valid = 4'b0101;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL rmw_ptr0: got %b required 0001", req_ready);
        end
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk); req_valid = '0; #1; seen = rsp_valid;
        end
        checks++;
        if (!seen || rsp_id !== 2'd0 || rsp_tag !== 4'h9 || rsp_sum !== fake_sum(32'h00010001, 32'h00020002)) begin
            errors++;
            $display("FAIL rmw_new: got seen=%b id=%0d tag=%h sum=%h required 1 0 9 %h",
                     seen, rsp_id, rsp_tag, rsp_sum, fake_sum(32'h00010001, 32'h00020002));
        end
    endtask

    // Random traffic against a transaction-level model: each request is
    // timed by its age in cycles since acceptance.
    task automatic test_random;
        logic [NUM_REQ-1:0] pend;
        logic [NUM_REQ-1:0] exp_ready;
        bit m_busy;
        int m_ptr, m_age, m_id, w;
        logic [31:0] m_a, m_b;
        logic [TAG_W-1:0] m_tag;
        do_reset();
        pend = '0; m_busy = 0; m_ptr = 0; m_age = 0; m_id = 0; m_a = '0; m_b = '0; m_tag = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (!pend[i] && $urandom_range(2) == 0) begin
                    pend[i] = 1'b1;
                    set_req(i, $urandom, $urandom, TAG_W'($urandom));
                end else if (pend[i] && $urandom_range(9) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            req_valid = pend;
            rsp_ready = ($urandom_range(3) != 0);
            #1;
            exp_ready = '0;
            w = m_busy ? -1 : rr_pick(req_valid, m_ptr);
            if (w >= 0) exp_ready[w] = 1'b1;
            checks++;
            if (req_ready !== exp_ready) begin
                errors++; $display("FAIL rnd_ready t%0d: got %b required %b", cyc, req_ready, exp_ready);
            end
            checks++;
            if (fpu_valid !== (m_busy && m_age == 1) || busy !== m_busy) begin
                errors++; $display("FAIL rnd_ctrl t%0d: got fv=%b busy=%b required %b %b",
                                   cyc, fpu_valid, busy, (m_busy && m_age == 1), m_busy);
            end
            checks++;
            if (rsp_valid !== (m_busy && m_age == int'(FPU_LAT) + 2)) begin
                errors++; $display("FAIL rnd_rsp_valid t%0d: got %b required %b",
                                   cyc, rsp_valid, (m_busy && m_age == int'(FPU_LAT) + 2));
            end
            if (m_busy && m_age >= 1 && m_age <= int'(FPU_LAT) + 1) begin
                checks++;
                if (fpu_a !== m_a || fpu_b !== m_b) begin
                    errors++; $display("FAIL rnd_operands t%0d: got %h %h required %h %h", cyc, fpu_a, fpu_b, m_a, m_b);
                end
            end
            if (m_busy && m_age == int'(FPU_LAT) + 2) begin
                checks++;
                if (rsp_id !== ID_W'(m_id) || rsp_tag !== m_tag || rsp_sum !== fake_sum(m_a, m_b) || rsp_error !== fake_err(m_a, m_b)) begin
                    errors++;
                    $display("FAIL rnd_rsp t%0d: got id=%0d tag=%h sum=%h err=%b required %0d %h %h %b",
                             cyc, rsp_id, rsp_tag, rsp_sum, rsp_error, m_id, m_tag, fake_sum(m_a, m_b), fake_err(m_a, m_b));
                end
            end
            if (w >= 0) begin
                m_busy = 1; m_age = 1; m_id = w;
                m_a = req_a[w*32 +: 32]; m_b = req_b[w*32 +: 32]; m_tag = req_tag[w*TAG_W +: TAG_W];
                pend[w] = 1'b0;
            end else if (m_busy) begin
                if (m_age == int'(FPU_LAT) + 2) begin
                    if (rsp_ready) begin
                        m_busy = 0;
                        m_ptr = (m_id + 1) % NUM_REQ;
                    end
                end else begin
                    m_age++;
                end
            end
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_exception();
        test_contention();
        test_fairness();
        test_backpressure();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
